hazard_scoreboard: RTL



---
 rtl/hazard_scoreboard.sv | 130 +++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks EX/MEM destination slots, registers forwarding selects, and raises load-use/flush bubbles.
// Define HAZARD_DIV_STALL_EN to compile in the multi-cycle divide stall FSM.
module hazard_scoreboard #(
  parameter int DIV_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  input  logic        ID_VALID,
  input  logic        ID_REG_WRITE,
  input  logic        ID_MEM_READ,
  input  logic        FLUSH,
  output logic        STALL,
  output logic        BUBBLE,
  output logic [1:0]  FWD_RS1,
  output logic [1:0]  FWD_RS2
);
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  assign opcode = INSTRUCTION[6:0];
  assign rd     = INSTRUCTION[11:7];
  assign rs1    = INSTRUCTION[19:15];
  assign rs2    = INSTRUCTION[24:20];

  logic rs1_op, rs2_op;
  always_comb begin
    rs1_op = 1'b0;
    rs2_op = 1'b0;
    case (opcode)
      OP_R, OP_ST, OP_BR:    begin rs1_op = 1'b1; rs2_op = 1'b1; end
      OP_I, OP_LD, OP_JALR:  rs1_op = 1'b1;
      default: ;
    endcase
  end

  // x0 and bubbles never create a dependency
  logic use1, use2;
  assign use1 = ID_VALID & rs1_op & (rs1 != 5'd0);
  assign use2 = ID_VALID & rs2_op & (rs2 != 5'd0);

  logic       ex_vld, ex_ld, mem_vld;
  logic [4:0] ex_rd, mem_rd;
  logic [1:0] sel1, sel2;
  assign sel1 = (use1 & ex_vld & (ex_rd == rs1))   ? 2'b11 :
                (use1 & mem_vld & (mem_rd == rs1)) ? 2'b01 : 2'b00;
  assign sel2 = (use2 & ex_vld & (ex_rd == rs2))   ? 2'b11 :
                (use2 & mem_vld & (mem_rd == rs2)) ? 2'b01 : 2'b00;

  logic load_use, busy, advance, id_wr;
  assign load_use = ex_vld & ex_ld & ((use1 & (rs1 == ex_rd)) | (use2 & (rs2 == ex_rd)));
  assign id_wr    = ID_VALID & ID_REG_WRITE & (rd != 5'd0);
  assign advance  = ~busy & ~FLUSH & ~load_use;
  assign STALL    = (load_use & ~FLUSH) | busy;
  assign BUBBLE   = ~busy & (FLUSH | load_use);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ex_vld  <= 1'b0;
      ex_ld   <= 1'b0;
      ex_rd   <= 5'd0;
      mem_vld <= 1'b0;
      mem_rd  <= 5'd0;
      FWD_RS1 <= 2'b00;
      FWD_RS2 <= 2'b00;
    end else if (busy) begin
      // divide occupies EX; nothing drains into MEM behind it
      mem_vld <= 1'b0;
    end else begin
      mem_vld <= ex_vld;
      mem_rd  <= ex_rd;
      if (advance) begin
        ex_vld  <= id_wr;
        ex_rd   <= rd;
        ex_ld   <= ID_MEM_READ;
        FWD_RS1 <= sel1;
        FWD_RS2 <= sel2;
      end else begin
        ex_vld  <= 1'b0;
        FWD_RS1 <= 2'b00;
        FWD_RS2 <= 2'b00;
      end
    end
  end

`ifdef HAZARD_DIV_STALL_EN
  typedef enum logic {IDLE, DIV_BUSY} state_t;
  localparam logic [2:0] CNT_INIT  = 3'(DIV_CYCLES - 1);
  localparam logic       DIV_MULTI = (DIV_CYCLES >= 2);

  state_t     state;
  logic [2:0] cnt;
  logic       is_div;
  assign is_div = ID_VALID & (opcode == OP_R) & (INSTRUCTION[31:25] == 7'b0000001) & INSTRUCTION[14];
  assign busy   = (state == DIV_BUSY);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      case (state)
        IDLE: if (advance & is_div & DIV_MULTI) begin
          state <= DIV_BUSY;
          cnt   <= CNT_INIT;
        end
        DIV_BUSY: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^INSTRUCTION[13:12];
`else
  assign busy = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{INSTRUCTION[31:25], INSTRUCTION[14:12], 1'(DIV_CYCLES)};
`endif
endmodule
